// File: rtl/handshake_pkg.sv
// Shared definitions for the req/grt handshake blocks: transfer counter
// width/type and the transfer-detect helper used by sources and drains.
package handshake_pkg;

    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    // A transfer completes in the cycle where request and grant are both high.
    function automatic logic is_xfer(input logic req, input logic grt);
        return req & grt;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for handshake_fifo: DEPTH x DW registers, one write port,
// one asynchronous read port. Deliberately unreset: contents only matter
// once written, and the head is only observed while the FIFO is non-empty.
module handshake_fifo_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Next array contents: copy current entries, overwrite the addressed one on a write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d[waddr] = mem_q[waddr];
        end
    end

    // Array register update (no reset by design).
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic buffer between two req/grt handshake domains. Acts as a drain
// upstream and a source downstream; keeps an occupancy level and a count
// of completed downstream transfers. Flags come from wrap-bit pointers, so
// every output is a function of registered state only.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_req,
    input  logic [DW-1:0] up_dat,
    output logic          up_grt,
    output logic          dn_req,
    output logic [DW-1:0] dn_dat,
    input  logic          dn_grt,
    output logic [AW:0]   level,
    output logic [31:0]   cnt
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam cnt_t        CNT_ONE = cnt_t'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    cnt_t        cnt_q, cnt_d;

    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign up_grt = !full_s;
    assign dn_req = !empty_s;
    assign level  = wr_ptr_q - rd_ptr_q;
    assign cnt    = cnt_q;

    // Transfer detection and next-state for pointers and transfer counter.
    always_comb begin
        push_s   = is_xfer(up_req, up_grt);
        pop_s    = is_xfer(dn_req, dn_grt);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            cnt_d    = cnt_q + CNT_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
        end
    end

    // Pointer and counter registers; reset empties the FIFO and clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    handshake_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (up_dat),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (dn_dat)
    );

endmodule

// File: tb/tb_handshake_fifo.sv
// Self-checking bench for handshake_fifo: a queue scoreboard holds accepted
// payloads and is compared against the DUT head on every downstream transfer.
module tb_handshake_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          up_req;
    logic [DW-1:0] up_dat;
    logic          up_grt;
    logic          dn_req;
    logic [DW-1:0] dn_dat;
    logic          dn_grt;
    logic [AW:0]   level;
    logic [31:0]   cnt;

    int          checks;
    int          errors;
    logic [7:0]  sb_q[$];
    logic [31:0] mcnt;
    logic [31:0] tot_push;
    logic        m_push;
    logic        m_pop;

    handshake_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .up_req (up_req),
        .up_dat (up_dat),
        .up_grt (up_grt),
        .dn_req (dn_req),
        .dn_dat (dn_dat),
        .dn_grt (dn_grt),
        .level  (level),
        .cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with current inputs: check handshake outputs before the
    // edge, update the scoreboard at the edge, check state after it.
    task automatic cyc();
        @(negedge clk);
        m_push = up_req && (sb_q.size() < DEPTH);
        m_pop  = dn_grt && (sb_q.size() > 0);
        chk("up_grt", {31'd0, up_grt}, {31'd0, sb_q.size() < DEPTH});
        chk("dn_req", {31'd0, dn_req}, {31'd0, sb_q.size() != 0});
        if (m_pop) chk("dn_dat", {24'd0, dn_dat}, {24'd0, sb_q[0]});
        @(posedge clk);
        #1;
        if (m_pop) begin
            void'(sb_q.pop_front());
            mcnt = mcnt + 32'd1;
        end
        if (m_push) begin
            sb_q.push_back(up_dat);
            tot_push = tot_push + 32'd1;
        end
        chk("level", {{(31-AW){1'b0}}, level}, sb_q.size());
        chk("cnt", cnt, mcnt);
        chk("conserve", cnt + {{(31-AW){1'b0}}, level}, tot_push);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] poly);
        logic [7:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ poly;
        return n;
    endfunction

    logic [7:0] lu;
    logic [7:0] ld;
    logic [7:0] pay;
    int         npush;
    int         guard;

    initial begin
        checks   = 0;
        errors   = 0;
        mcnt     = 32'd0;
        tot_push = 32'd0;
        rst      = 1'b1;
        up_req   = 1'b0;
        up_dat   = 8'd0;
        dn_grt   = 1'b0;
        #2;
        chk("por_level", {{(31-AW){1'b0}}, level}, 32'd0);
        chk("por_up_grt", {31'd0, up_grt}, 32'd1);
        chk("por_dn_req", {31'd0, dn_req}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Test 1: fill to 3 then assert reset between edges
        up_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_dat = 8'hA0 + 8'(i);
            cyc();
        end
        up_req = 1'b0;
        chk("pre_rst_level", {{(31-AW){1'b0}}, level}, 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_level", {{(31-AW){1'b0}}, level}, 32'd0);
        chk("rst_dn_req", {31'd0, dn_req}, 32'd0);
        chk("rst_up_grt", {31'd0, up_grt}, 32'd1);
        chk("rst_cnt", cnt, 32'd0);
        sb_q.delete();
        mcnt     = 32'd0;
        tot_push = 32'd0;
        #1;
        rst = 1'b0;

        // Test 2: fill to full, extra request refused
        dn_grt = 1'b0;
        up_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dat = 8'h11 * 8'(i + 1);
            cyc();
        end
        chk("full_up_grt", {31'd0, up_grt}, 32'd0);
        up_dat = 8'h55;
        cyc();
        chk("full_level", {{(31-AW){1'b0}}, level}, 32'd4);

        // Test 3: drain in order
        up_req = 1'b0;
        dn_grt = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("drain_cnt", cnt, 32'd4);
        chk("drain_empty", {31'd0, dn_req}, 32'd0);

        // Test 4: full with simultaneous pop, then push next cycle
        dn_grt = 1'b0;
        up_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dat = 8'hC0 + 8'(i);
            cyc();
        end
        dn_grt = 1'b1;
        up_dat = 8'hC4;
        cyc();
        chk("fullpop_level", {{(31-AW){1'b0}}, level}, 32'd3);
        up_dat = 8'hC5;
        cyc();
        chk("fullpop_push_level", {{(31-AW){1'b0}}, level}, 32'd3);
        up_req = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        // Test 5: random-stall stream of 1000 items
        lu    = 8'h01;
        ld    = 8'h01;
        pay   = 8'h00;
        npush = 0;
        guard = 0;
        while (npush < 1000 && guard < 20000) begin
            up_req = lu[0];
            dn_grt = ld[0];
            up_dat = pay;
            cyc();
            if (m_push) begin
                pay   = pay + 8'd1;
                npush = npush + 1;
            end
            lu    = lfsr_step(lu, 8'hE1);
            ld    = lfsr_step(ld, 8'hD4);
            guard = guard + 1;
        end
        chk("stream_timeout", npush, 32'd1000);
        up_req = 1'b0;
        guard  = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            dn_grt = ld[0];
            cyc();
            ld    = lfsr_step(ld, 8'hD4);
            guard = guard + 1;
        end
        chk("stream_drained", {31'd0, dn_req}, 32'd0);

        // Test 6: transfer counter wrap
        dn_grt = 1'b0;
        up_req = 1'b1;
        up_dat = 8'h5A;
        cyc();
        up_req = 1'b0;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        mcnt     = 32'hFFFF_FFFF;
        tot_push = mcnt + sb_q.size();
        chk("forced_cnt", cnt, 32'hFFFF_FFFF);
        dn_grt = 1'b1;
        cyc();
        chk("cnt_wrap", cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_fifo.md
# handshake_fifo

Elastic buffer stage for the req/grt handshake used between source and drain blocks. It carries a data payload and decouples the two random-stall domains. Upstream it acts as a drain (accepts on `up_req & up_grt`); downstream it acts as a source (offers on `dn_req`, completes on `dn_req & dn_grt`). It also keeps an occupancy level and a completed-transfer counter so benches can check conservation of transfers end to end.

## Interface

Parameters:
- `DW`, 8, payload width in bits
- `DEPTH`, 4, number of storage entries; power of two, ≥ 2
- `AW`, `$clog2(DEPTH)`, derived pointer width; not overridden

Ports:
- `clk` input 1: clock, all state on posedge
- `rst` input 1: reset, asynchronous, active-high
- `up_req` input 1: upstream offers `up_dat`
- `up_dat` input DW: upstream payload
- `up_grt` output 1: FIFO can accept this cycle
- `dn_req` output 1: FIFO offers `dn_dat`
- `dn_dat` output DW: head-of-FIFO payload
- `dn_grt` input 1: downstream accepts this cycle
- `level` output AW+1: entries currently stored, range 0..DEPTH
- `cnt` output 32: count of completed downstream transfers

## Operation

- Push: `push = up_req & up_grt`. Pop: `pop = dn_req & dn_grt`. A transfer is the cycle where both signals are high; neither side waits on the other's signal.
- `up_grt = !full`. It depends only on state, never on `up_req`.
- `dn_req = !empty`. It depends only on state, never on `dn_grt`.
- `dn_dat` = `mem[rd_ptr]`. It is stable while `dn_req` is high and no pop occurs.
- Pointers `wr_ptr`, `rd_ptr` are AW+1 bits wide; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: low AW bits equal and MSBs differ.
- `level = wr_ptr - rd_ptr`, modulo 2^(AW+1).
- Push writes `mem[wr_ptr[AW-1:0]]` and increments `wr_ptr`. Pop increments `rd_ptr`. Pointers wrap naturally.
- Simultaneous push and pop when not empty and not full: both happen and `level` is unchanged.
- Full: `up_grt` is 0, so no push occurs. A pop in the same cycle frees a slot, but `up_grt` rises only on the next cycle. There is no bypass.
- Empty: `dn_req` is 0, so no pop occurs. A push in the same cycle is visible on `dn_req` the next cycle. There is no fall-through.
- `cnt` increments by 1 on each pop. It is 32-bit unsigned and wraps from 0xFFFF_FFFF to 0.
- Reset mid-operation discards all stored data. Memory contents are not cleared and don't matter, since `dn_dat` is don't-care while `dn_req` is 0.
- Reset values:
  - `wr_ptr`, `rd_ptr`, `level`, `cnt`: 0
  - `up_grt`: 1
  - `dn_req`: 0
  - `dn_dat`: don't-care

## Timing

- Latency is 1 cycle. Data pushed at edge N is offered on `dn_req`/`dn_dat` after edge N and can pop at edge N+1.
- Throughput is one push and one pop per cycle sustained when 0 < `level` < DEPTH.
- All outputs are registered or derived from registered state only. There is no combinational path from any input to any output.
- Asynchronous reset assertion clears state immediately. Reset release is assumed to be synchronised to `clk` externally.

## Structure

- Shared package `handshake_pkg` holds:
  - `CNT_W = 32`
  - typedef `cnt_t` (`logic [CNT_W-1:0]`)
  - function `is_xfer(req, grt)`, returning `req & grt`, reused by source and drain counters.
- Storage is a sub-module `handshake_fifo_mem`: DEPTH × DW register array, 1 write port, 1 async read port, no reset.
- The pointer/flag/counter logic stays in `handshake_fifo`.

## Test plan

1. **Reset.** Hold `rst=1` mid-stream with `level=3`. Required: `level=0`, `dn_req=0`, `up_grt=1`, `cnt=0` while reset is asserted, with no clock edge needed.
2. **Fill to full.** DEPTH=4, `dn_grt=0`, push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   - `level` steps 1, 2, 3, 4.
   - `up_grt=0` after the 4th push.
   - A 5th `up_req` with 0x55 is not accepted.
3. **Drain in order.** From case 2, set `dn_grt=1`.
   - `dn_dat` reads 0x11, 0x22, 0x33, 0x44 on successive pops, then `dn_req=0`.
   - `cnt=4`; `up_grt` returns to 1 one cycle after the first pop.
4. **Full with simultaneous pop.** At `level=4`, `up_req=1`, `dn_grt=1`.
   - Pop occurs; no push in that cycle.
   - `level=3`, then push accepted next cycle, giving `level=3` again.
5. **Pointer wrap.** Stream 1000 items using the 8-bit LFSRs with polynomial 0xE1 upstream and 0xD4 downstream, payload an incrementing byte.
   - Output sequence equals input sequence.
   - `cnt` + `level` equals the push count every cycle.
6. **Counter wrap.** Force `cnt` to 0xFFFF_FFFF, then perform one pop. Required: `cnt=0`.
